// File: rtl/ser2par_deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Holds the bit-order encodings, the frame-state enum and the counter width derivation.
package ser2par_deser_pkg;

    localparam bit LSB_FIRST_ENC = 1'b1;
    localparam bit MSB_FIRST_ENC = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } frame_state_t;

    // Counter must hold the value W itself, since W is a legal frame length.
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ser2par_deser_if.sv
// Serial source / parallel consumer bundle for ser2par_deser.
// slave is the deserializer side; master is the side that drives bits and consumes words.
interface ser2par_deser_if
    import ser2par_deser_pkg::*;
#(
    parameter int W = 8
);
    localparam int CW = cw_of(W);

    logic          init;
    logic          si;
    logic          si_valid;
    logic [CW-1:0] frame_len;
    logic [W-1:0]  po;
    logic          po_valid;
    logic          po_ready;
    logic          co;
    logic [CW-1:0] bit_cnt;
    logic          ovf;

    modport slave (
        input  init, si, si_valid, frame_len, po_ready,
        output po, po_valid, co, bit_cnt, ovf
    );

    modport master (
        output init, si, si_valid, frame_len, po_ready,
        input  po, po_valid, co, bit_cnt, ovf
    );

endinterface

// File: rtl/ser2par_deser_bit_counter.sv
// Frame bit counter: counts accepted bits against a per-frame length latched on the first bit.
// State table:  ST_IDLE | no bits of the current frame received (cnt==0)
//               ST_SHIFT| mid-frame, len_q holds the frame length
module ser2par_deser_bit_counter
    import ser2par_deser_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] len,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] len_eff,
    output logic          co
);

    frame_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        // Live length on the first bit so a 1-bit frame terminates immediately.
        len_eff = (state_q == ST_IDLE) ? len : len_q;
        co      = en & ~clr & (cnt_q == (len_eff - CW'(1)));

        if (clr) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    len_d = len;
                    if (!co) begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (co) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ser2par_deser.sv
// Serial-in/parallel-out deserializer with runtime frame length and a valid/ready holding register.
// Completed frames arriving while the holding register is full are dropped and flagged in ovf.
module ser2par_deser
    import ser2par_deser_pkg::*;
#(
    parameter int W         = 8,
    parameter bit LSB_FIRST = LSB_FIRST_ENC
) (
    input  logic                 clk,
    input  logic                 rst,
    ser2par_deser_if.slave       bus
);

    localparam int            CW   = cw_of(W);
    localparam logic [CW-1:0] W_CW = CW'(W);

    logic [W-1:0]  sh_q;
    logic [W-1:0]  sh_shift;
    logic [W-1:0]  frame_word;
    logic [W-1:0]  po_q;
    logic          po_valid_q;
    logic          ovf_q;
    logic [CW-1:0] len_san;
    logic [CW-1:0] len_eff;
    logic [CW-1:0] bit_cnt;
    logic          co;
    logic          accept;
    logic          room;

    ser2par_deser_bit_counter #(.CW(CW)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.init),
        .en      (bus.si_valid),
        .len     (len_san),
        .cnt     (bit_cnt),
        .len_eff (len_eff),
        .co      (co)
    );

    always_comb begin
        len_san = bus.frame_len;
        if (bus.frame_len == '0 || bus.frame_len > W_CW) begin
            len_san = W_CW;
        end

        if (LSB_FIRST) begin
            sh_shift   = {bus.si, sh_q[W-1:1]};
            frame_word = sh_shift >> (W_CW - len_eff);
        end else begin
            sh_shift   = {sh_q[W-2:0], bus.si};
            frame_word = sh_shift & ({W{1'b1}} >> (W_CW - len_eff));
        end

        accept = po_valid_q & bus.po_ready;
        room   = ~po_valid_q | bus.po_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q       <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (bus.init) begin
                sh_q <= '0;
            end else if (bus.si_valid) begin
                sh_q <= co ? '0 : sh_shift;
            end

            if (co) begin
                if (room) begin
                    po_q       <= frame_word;
                    po_valid_q <= 1'b1;
                end
            end else if (accept) begin
                po_valid_q <= 1'b0;
            end

            if (bus.init) begin
                ovf_q <= 1'b0;
            end else if (co && !room) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.po       = po_q;
    assign bus.po_valid = po_valid_q;
    assign bus.co       = co;
    assign bus.bit_cnt  = bit_cnt;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_ser2par_deser.sv
// Bench for ser2par_deser: an LSB-first and an MSB-first instance share one stimulus stream
// and are compared every cycle against a frame-level model built from collected bit lists.
module tb_ser2par_deser;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ser2par_deser_if #(.W(W)) bus_l ();
    ser2par_deser_if #(.W(W)) bus_m ();

    ser2par_deser #(.W(W), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));
    ser2par_deser #(.W(W), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));

    int total = 0;
    int bad   = 0;

    // frame-level reference state
    bit       q_bits[$];
    int       m_len = 0;
    logic [7:0] m_po_l = '0;
    logic [7:0] m_po_m = '0;
    logic     m_pv  = 1'b0;
    logic     m_ovf = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int san(input int fl);
        return (fl == 0 || fl > W) ? W : fl;
    endfunction

    task automatic drive(input logic i_init, input logic i_si, input logic i_sv,
                         input logic [CW-1:0] fl, input logic rdy);
        bus_l.init = i_init;   bus_m.init = i_init;
        bus_l.si = i_si;       bus_m.si = i_si;
        bus_l.si_valid = i_sv; bus_m.si_valid = i_sv;
        bus_l.frame_len = fl;  bus_m.frame_len = fl;
        bus_l.po_ready = rdy;  bus_m.po_ready = rdy;
    endtask

    // One clock: drive, check combinational outputs, advance the model, check registered outputs.
    task automatic step(input logic i_rst, input logic i_init, input logic i_si, input logic i_sv,
                        input logic [CW-1:0] fl, input logic rdy);
        int  L;
        bit  e_co;
        bit  acc, room;
        logic [7:0] wl, wm;
        rst = i_rst;
        drive(i_init, i_si, i_sv, fl, rdy);
        #1;
        L    = (q_bits.size() == 0) ? san(int'(fl)) : m_len;
        e_co = i_sv && !i_init && (q_bits.size() == L - 1);
        check_val("co_l", 32'(bus_l.co), 32'(e_co));
        check_val("co_m", 32'(bus_m.co), 32'(e_co));
        check_val("bit_cnt", 32'(bus_l.bit_cnt), 32'(q_bits.size()));

        if (i_rst) begin
            q_bits.delete();
            m_len = 0; m_po_l = '0; m_po_m = '0; m_pv = 1'b0; m_ovf = 1'b0;
        end else begin
            acc  = m_pv && rdy;
            room = !m_pv || rdy;
            if (i_init) begin
                q_bits.delete();
                m_ovf = 1'b0;
            end else if (i_sv) begin
                if (q_bits.size() == 0) m_len = L;
                q_bits.push_back(i_si);
                if (e_co) begin
                    wl = '0; wm = '0;
                    foreach (q_bits[i]) begin
                        wl = wl | (8'(q_bits[i]) << i);
                        wm = wm | (8'(q_bits[i]) << (L - 1 - i));
                    end
                    q_bits.delete();
                    if (room) begin
                        m_po_l = wl; m_po_m = wm; m_pv = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (!e_co && acc) m_pv = 1'b0;
        end

        @(posedge clk);
        #1;
        check_val("po_l", 32'(bus_l.po), 32'(m_po_l));
        check_val("po_m", 32'(bus_m.po), 32'(m_po_m));
        check_val("po_valid", 32'(bus_l.po_valid), 32'(m_pv));
        check_val("po_valid_m", 32'(bus_m.po_valid), 32'(m_pv));
        check_val("ovf", 32'(bus_l.ovf), 32'(m_ovf));
        check_val("bit_cnt_m", 32'(bus_m.bit_cnt), 32'(q_bits.size()));
    endtask

    // Sends n bits, first transmitted bit is b[n-1].
    task automatic send_bits(input logic [7:0] b, input int n, input logic [CW-1:0] fl, input logic rdy);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, b[i], 1'b1, fl, rdy);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
        check_val("rst_po", 32'(bus_l.po), 32'h0);
        check_val("rst_pv", 32'(bus_l.po_valid), 32'h0);

        // 8-bit LSB-first frame
        send_bits(8'b10110010, 8, 4'd8, 1'b1);
        check_val("t1_po", 32'(bus_l.po), 32'h4D);
        check_val("t1_pv", 32'(bus_l.po_valid), 32'h1);

        // 5-bit then 3-bit frames back to back
        send_bits(8'b00010110, 5, 4'd5, 1'b1);
        check_val("t2_po_m", 32'(bus_m.po), 32'h16);
        send_bits(8'b00000111, 3, 4'd3, 1'b1);
        check_val("t2b_po_m", 32'(bus_m.po), 32'h07);

        // drain, then overflow with consumer stalled
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1);
        send_bits(8'b00000101, 4, 4'd4, 1'b0);
        send_bits(8'b00001010, 4, 4'd4, 1'b0);
        check_val("t3_po", 32'(bus_l.po), 32'h0A);
        check_val("t3_ovf", 32'(bus_l.ovf), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1);
        check_val("t3_pv", 32'(bus_l.po_valid), 32'h0);

        // init mid-frame, then an all-ones frame; also clears ovf
        send_bits(8'b00000010, 3, 4'd8, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0);
        check_val("t5_ovf", 32'(bus_l.ovf), 32'h0);
        send_bits(8'hFF, 8, 4'd8, 1'b0);
        check_val("t5_po", 32'(bus_l.po), 32'hFF);
        check_val("t5_cnt", 32'(bus_l.bit_cnt), 32'h0);

        // completion while a word is pending and being consumed
        send_bits(8'b00001100, 4, 4'd4, 1'b1);
        check_val("t4_pv", 32'(bus_l.po_valid), 32'h1);
        check_val("t4_ovf", 32'(bus_l.ovf), 32'h0);

        // reset mid-frame with a pending word, then a frame_len=0 frame
        send_bits(8'b00000011, 2, 4'd8, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
        check_val("t6_po", 32'(bus_l.po), 32'h0);
        check_val("t6_pv", 32'(bus_l.po_valid), 32'h0);
        send_bits(8'b11000101, 8, 4'd0, 1'b1);
        check_val("t6_po8", 32'(bus_l.po), 32'hA3);

        // randomized traffic including 1-bit and oversized lengths
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
                 1'($urandom), ($urandom_range(0, 3) != 0),
                 CW'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
